// File: rtl/mem_refill_ctrl_pkg.sv
// Shared widths, state encodings and helpers for the miss refill controller.
package mem_refill_ctrl_pkg;

    localparam int unsigned BLOCK_W      = 128;
    localparam int unsigned BLOCK_ADDR_W = 10;
    localparam int unsigned STATE_W      = 3;

    localparam logic [STATE_W-1:0] MRC_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] MRC_WB   = 3'd1;
    localparam logic [STATE_W-1:0] MRC_TURN = 3'd2;
    localparam logic [STATE_W-1:0] MRC_RD   = 3'd3;
    localparam logic [STATE_W-1:0] MRC_DONE = 3'd4;

    typedef logic [BLOCK_W-1:0] block_t;

    // Width needed to count up to the larger of the two phase lengths.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mem_refill_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at all-ones; async active-low clear.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (en && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/mem_refill_ctrl.sv
// Cache miss engine: optional dirty write-back, then line read from block RAM.
// Optional statistics counters are built when REFILL_STATS_EN is defined.
module mem_refill_ctrl
    import mem_refill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = BLOCK_ADDR_W,
    parameter int unsigned WR_CYC = 2,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              Rst_Low,
    input  logic              Miss_Req,
    input  logic [ADDR_W-1:0] Miss_Addr,
    input  logic              Dirty,
    input  logic [ADDR_W-1:0] Victim_Addr,
    input  block_t            Victim_Data,
    output logic              Miss_Ack,
    output block_t            Refill_Data,
    output logic              Busy,
    output logic              Mem_Req_Low,
    output logic [ADDR_W-1:0] Mem_Addr,
    output block_t            Mem_Din,
    output logic              Mem_Wr,
    input  block_t            Mem_Dout,
    input  logic              Mem_Rdy_Low
`ifdef REFILL_STATS_EN
    ,
    output logic [15:0]       Miss_Cnt,
    output logic [15:0]       Wb_Cnt
`endif
);

    localparam int unsigned CNT_W = cnt_width(WR_CYC, RD_LAT);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               guard_q, guard_d;
    logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;

    logic               req_low_d, wr_d, ack_d, busy_d;
    logic [ADDR_W-1:0]  addr_d;
    block_t             din_d, refill_d;

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        guard_d     = guard_q;
        miss_addr_d = miss_addr_q;
        req_low_d   = Mem_Req_Low;
        wr_d        = Mem_Wr;
        addr_d      = Mem_Addr;
        din_d       = Mem_Din;
        refill_d    = Refill_Data;
        ack_d       = 1'b0;

        case (state_q)
            MRC_IDLE: begin
                // A request still high from the ack cycle must not be served twice.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (Miss_Req) begin
                    miss_addr_d = Miss_Addr;
                    cnt_d       = '0;
                    req_low_d   = 1'b0;
                    if (Dirty) begin
                        state_d = MRC_WB;
                        wr_d    = 1'b1;
                        addr_d  = Victim_Addr;
                        din_d   = Victim_Data;
                    end else begin
                        state_d = MRC_RD;
                        wr_d    = 1'b0;
                        addr_d  = Miss_Addr;
                    end
                end
            end
            MRC_WB: begin
                if (!Mem_Rdy_Low) begin
                    if (cnt_q == CNT_W'(WR_CYC - 1)) begin
                        state_d   = MRC_TURN;
                        cnt_d     = '0;
                        req_low_d = 1'b1;
                        wr_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            MRC_TURN: begin
                state_d   = MRC_RD;
                cnt_d     = '0;
                req_low_d = 1'b0;
                wr_d      = 1'b0;
                addr_d    = miss_addr_q;
            end
            MRC_RD: begin
                if (!Mem_Rdy_Low) begin
                    if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                        state_d   = MRC_DONE;
                        cnt_d     = '0;
                        refill_d  = Mem_Dout;
                        ack_d     = 1'b1;
                        req_low_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            MRC_DONE: begin
                state_d = MRC_IDLE;
                cnt_d   = '0;
                guard_d = 1'b1;
            end
            default: begin
                state_d   = MRC_IDLE;
                cnt_d     = '0;
                req_low_d = 1'b1;
                wr_d      = 1'b0;
            end
        endcase

        busy_d = (state_d != MRC_IDLE);
    end

    always_ff @(posedge clk or negedge Rst_Low) begin
        if (!Rst_Low) begin
            state_q     <= MRC_IDLE;
            cnt_q       <= '0;
            guard_q     <= 1'b0;
            miss_addr_q <= '0;
            Mem_Req_Low <= 1'b1;
            Mem_Wr      <= 1'b0;
            Mem_Addr    <= '0;
            Mem_Din     <= '0;
            Refill_Data <= '0;
            Miss_Ack    <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            guard_q     <= guard_d;
            miss_addr_q <= miss_addr_d;
            Mem_Req_Low <= req_low_d;
            Mem_Wr      <= wr_d;
            Mem_Addr    <= addr_d;
            Mem_Din     <= din_d;
            Refill_Data <= refill_d;
            Miss_Ack    <= ack_d;
            Busy        <= busy_d;
        end
    end

`ifdef REFILL_STATS_EN
    logic accept_c;
    logic wb_entry_c;

    assign accept_c   = (state_q == MRC_IDLE) && !guard_q && Miss_Req;
    assign wb_entry_c = accept_c && Dirty;

    sat_counter16 u_miss_cnt (
        .clk   (clk),
        .rst_n (Rst_Low),
        .en    (accept_c),
        .cnt   (Miss_Cnt)
    );

    sat_counter16 u_wb_cnt (
        .clk   (clk),
        .rst_n (Rst_Low),
        .en    (wb_entry_c),
        .cnt   (Wb_Cnt)
    );
`endif

endmodule
